// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: IDLE/RUN/PAUSE/LAP FSM, 1 Hz prescaler, mm:ss counters, lap snapshot.
// Define STOPWATCH_BCD_EN to present sec/min as packed two-digit BCD instead of plain binary.
module stopwatch_ctrl #(
    parameter int CLK_DIV = 50000000,
    parameter int MAX_MIN = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       lap_clear,
    output logic [7:0] sec,
    output logic [7:0] min,
    output logic       tick_out,
    output logic       running,
    output logic       lap_active,
    output logic       overflow
);

    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

`ifdef STOPWATCH_BCD_EN
    localparam logic [7:0] SEC_LAST = 8'h59;
    localparam logic [7:0] MIN_LAST = 8'(((MAX_MIN / 10) * 16) + (MAX_MIN % 10));

    // Two-digit BCD increment; callers never pass the wrap value.
    function automatic logic [7:0] inc_enc(input logic [7:0] v);
        if (v[3:0] == 4'd9) inc_enc = {v[7:4] + 4'd1, 4'd0};
        else                inc_enc = {v[7:4], v[3:0] + 4'd1};
    endfunction
`else
    localparam logic [7:0] SEC_LAST = 8'd59;
    localparam logic [7:0] MIN_LAST = 8'(MAX_MIN);

    function automatic logic [7:0] inc_enc(input logic [7:0] v);
        inc_enc = v + 8'd1;
    endfunction
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_LAP} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    tsec_q, tsec_d, tmin_q, tmin_d;
    logic [7:0]    snap_sec_q, snap_sec_d, snap_min_q, snap_min_d;
    logic          ovf_q, ovf_d, tick_q, tick_d;
    logic [7:0]    sec_q, min_q;
    logic          running_q, lap_q;
    logic          terminal;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        presc_d    = presc_q;
        tsec_d     = tsec_q;
        tmin_d     = tmin_q;
        snap_sec_d = snap_sec_q;
        snap_min_d = snap_min_q;
        ovf_d      = ovf_q;
        tick_d     = 1'b0;
        terminal   = (presc_q == PRESC_LAST);

        case (state_q)
            S_IDLE: begin
                if (start_stop) begin
                    state_d = S_RUN;
                    presc_d = '0;
                end
            end
            S_RUN, S_LAP: begin
                presc_d = terminal ? '0 : presc_q + PW'(1);
                if (start_stop) begin
                    state_d = S_PAUSE;
                end else if (lap_clear) begin
                    if (state_q == S_RUN) begin
                        state_d    = S_LAP;
                        snap_sec_d = tsec_q;
                        snap_min_d = tmin_q;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                // Saturation overrides any command and parks the machine in PAUSE.
                if (terminal) begin
                    if (tsec_q == SEC_LAST && tmin_q == MIN_LAST) begin
                        ovf_d   = 1'b1;
                        state_d = S_PAUSE;
                    end else begin
                        tick_d = 1'b1;
                        if (tsec_q == SEC_LAST) begin
                            tsec_d = '0;
                            tmin_d = inc_enc(tmin_q);
                        end else begin
                            tsec_d = inc_enc(tsec_q);
                        end
                    end
                end
            end
            S_PAUSE: begin
                if (start_stop) begin
                    state_d = S_RUN;
                end else if (lap_clear) begin
                    state_d = S_IDLE;
                    presc_d = '0;
                    tsec_d  = '0;
                    tmin_d  = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            tsec_q     <= '0;
            tmin_q     <= '0;
            snap_sec_q <= '0;
            snap_min_q <= '0;
            ovf_q      <= 1'b0;
            tick_q     <= 1'b0;
            sec_q      <= '0;
            min_q      <= '0;
            running_q  <= 1'b0;
            lap_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            tsec_q     <= tsec_d;
            tmin_q     <= tmin_d;
            snap_sec_q <= snap_sec_d;
            snap_min_q <= snap_min_d;
            ovf_q      <= ovf_d;
            tick_q     <= tick_d;
            // Display registers follow the next state so they line up with it after the edge.
            sec_q      <= (state_d == S_LAP) ? snap_sec_d : tsec_d;
            min_q      <= (state_d == S_LAP) ? snap_min_d : tmin_d;
            running_q  <= (state_d == S_RUN) || (state_d == S_LAP);
            lap_q      <= (state_d == S_LAP);
        end
    end

    assign sec        = sec_q;
    assign min        = min_q;
    assign tick_out   = tick_q;
    assign running    = running_q;
    assign lap_active = lap_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed scoreboard bench for stopwatch_ctrl with CLK_DIV=4; honours STOPWATCH_BCD_EN for display encoding.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_stop = 1'b0;
    logic       lap_clear = 1'b0;
    logic [7:0] sec, min;
    logic       tick_out, running, lap_active, overflow;

    stopwatch_ctrl #(.CLK_DIV(4), .MAX_MIN(99)) dut (
        .clk(clk), .rst(rst), .start_stop(start_stop), .lap_clear(lap_clear),
        .sec(sec), .min(min), .tick_out(tick_out), .running(running),
        .lap_active(lap_active), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    // Reference model of the stopwatch as seen from outside.
    int ph = 0;
    int tk = 0;
    int snap = 0;
    bit lap_m = 1'b0;

    function automatic logic [7:0] enc(input int v);
`ifdef STOPWATCH_BCD_EN
        enc = 8'(((v / 10) * 16) + (v % 10));
`else
        enc = 8'(v);
`endif
    endfunction

    function automatic logic [31:0] pack(input int s, input int m, input bit t, input bit r,
                                         input bit l, input bit o);
        pack = {12'd0, enc(s), enc(m), t, r, l, o};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %05h expected %05h (sec,min,tick,run,lap,ovf)", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit ss, input bit lc);
        start_stop = ss;
        lap_clear  = lc;
        @(posedge clk);
        #1;
        start_stop = 1'b0;
        lap_clear  = 1'b0;
    endtask

    task automatic expect_after(input string tag, input bit ss, input bit lc, input int s, input int m,
                                input bit t, input bit r, input bit l, input bit o);
        exp_t e;
        sb.push_back('{tag, pack(s, m, t, r, l, o)});
        cycle(ss, lc);
        e = sb.pop_front();
        check(e.tag, {12'd0, sec, min, tick_out, running, lap_active, overflow}, e.val);
    endtask

    // Advance n cycles in RUN/LAP with no commands.
    task automatic run_n(input int n, input string tag);
        bit t;
        int shown;
        for (int i = 0; i < n; i++) begin
            ph++;
            t = (ph == 4);
            if (t) begin
                ph = 0;
                tk++;
            end
            shown = lap_m ? snap : tk;
            expect_after(tag, 1'b0, 1'b0, shown % 60, shown / 60, t, 1'b1, lap_m, 1'b0);
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        expect_after(tag, 1'($urandom_range(1)), 1'($urandom_range(1)), 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        ph = 0;
        tk = 0;
        lap_m = 1'b0;
    endtask

    task automatic start_run(input string tag);
        ph = 0;
        expect_after(tag, 1'b1, 1'b0, tk % 60, tk / 60, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #2;
        // 1. Reset held three cycles with random command noise.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_after("reset_hold", 1'($urandom_range(1)), 1'($urandom_range(1)), 0, 0, 0, 0, 0, 0);
        end
        rst = 1'b0;

        // 2. Count 240 cycles: 60 ticks every 4 cycles, ends at 1:00.
        start_run("count_start");
        run_n(240, "count_wrap");

        // 3. Pause two cycles after the 10th tick, hold, resume.
        do_reset("reset_t3");
        start_run("pr_start");
        run_n(41, "pr_run");
        ph++;
        expect_after("pause", 1'b1, 1'b0, 10, 0, 0, 0, 0, 0);
        for (int i = 0; i < 100; i++) expect_after("pause_hold", 1'b0, 1'b0, 10, 0, 0, 0, 0, 0);
        expect_after("resume", 1'b1, 1'b0, 10, 0, 0, 1, 0, 0);
        run_n(2, "resume_tick");

        // 4. Lap freeze at 5 s, three more ticks, release shows 8 s.
        do_reset("reset_t4");
        start_run("lap_start");
        run_n(20, "lap_pre");
        ph++;
        snap = tk;
        lap_m = 1'b1;
        expect_after("lap_enter", 1'b0, 1'b1, 5, 0, 0, 1, 1, 0);
        run_n(12, "lap_frozen");
        ph++;
        lap_m = 1'b0;
        expect_after("lap_release", 1'b0, 1'b1, 8, 0, 0, 1, 0, 0);

        // 6a. Both commands in IDLE: start wins.
        do_reset("reset_t6");
        expect_after("both_in_idle", 1'b1, 1'b1, 0, 0, 0, 1, 0, 0);
        // 6c. start_stop on terminal count: tick applied, then PAUSE with prescaler cleared.
        ph = 0;
        run_n(3, "tc_pre");
        tk++;
        expect_after("stop_on_tc", 1'b1, 1'b0, 1, 0, 1, 0, 0, 0);
        start_run("tc_resume");
        run_n(4, "tc_after_resume");
        // 6b. Reset mid-RUN at 7 s.
        run_n(20, "to_sec7");
        run_n(1, "at_sec7");
        do_reset("reset_mid_run");

        // 5. Run to saturation, hold, then clear.
        start_run("ovf_start");
        run_n(23999, "ovf_run");
        expect_after("saturate", 1'b0, 1'b0, 59, 99, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) expect_after("sat_hold", 1'b0, 1'b0, 59, 99, 0, 0, 0, 1);
        expect_after("clear", 1'b0, 1'b1, 0, 0, 0, 0, 0, 0);
        expect_after("idle_lap_ignored", 1'b0, 1'b1, 0, 0, 0, 0, 0, 0);
        expect_after("idle_restart", 1'b1, 1'b0, 0, 0, 0, 1, 0, 0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Sequencing controller for the seconds stopwatch datapath. It decodes one-cycle start/stop and lap/clear command pulses into an IDLE/RUN/PAUSE/LAP state machine. It owns the 1 Hz prescaler and the minutes:seconds counters. It also presents either the live time or a frozen lap snapshot to the display path.

Parameters:
CLK_DIV, 50000000, clk cycles per 1 s tick (minimum 2; benches use 4)
MAX_MIN, 99, highest minutes value before overflow

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
start_stop  input  1  one-cycle command pulse: start/pause/resume
lap_clear  input  1  one-cycle command pulse: lap freeze/release, or clear when paused
sec  output  8  displayed seconds, 0..59 (encoding per Optional Feature)
min  output  8  displayed minutes, 0..MAX_MIN
tick_out  output  1  one-cycle pulse, high in the cycle the internal time advances
running  output  1  high in RUN and LAP
lap_active  output  1  high in LAP (display frozen)
overflow  output  1  sticky, set on saturation at MAX_MIN:59

Behaviour:
- Clocking and reset: one clock domain, clk. Reset is synchronous and active-high on rst.
- With rst high at a clk edge, after that edge:
  - state=IDLE
  - prescaler=0
  - internal sec/min=0
  - lap snapshot=0
  - all outputs 0
- rst has priority over everything, including mid-RUN.
- All outputs are registered.
- States: IDLE, RUN, PAUSE, LAP.
- Command priority: if start_stop and lap_clear are high in the same cycle, start_stop acts and lap_clear is ignored.
- IDLE:
  - start_stop -> RUN, with prescaler=0.
  - lap_clear is ignored.
- RUN:
  - Prescaler increments every cycle.
  - At CLK_DIV-1 the prescaler wraps to 0 and the internal time advances.
  - The new sec/min and tick_out=1 appear after that same edge.
  - The first advance after the start edge occurs exactly CLK_DIV edges later.
  - start_stop -> PAUSE; the prescaler value is held.
  - lap_clear -> LAP; the snapshot captures the current internal time.
- LAP:
  - Counting continues exactly as in RUN.
  - sec/min outputs show the snapshot.
  - lap_clear -> RUN; display goes live on the next cycle.
  - start_stop -> PAUSE; display goes live.
- PAUSE:
  - Prescaler and time are frozen; tick_out=0.
  - start_stop -> RUN, resuming from the held prescaler value. A partial second is not lost.
  - lap_clear -> IDLE, clearing the time, prescaler and overflow.
- Time arithmetic:
  - sec wraps 59->0 with min+1.
  - At MAX_MIN:59 the next terminal count does not wrap. Time saturates at MAX_MIN:59, overflow=1, and the state goes to PAUSE. tick_out is not asserted for that count.
  - overflow clears only via rst or a clear from PAUSE.
- Terminal count coinciding with start_stop in RUN: the increment is applied (tick_out=1) and the state still goes to PAUSE, with prescaler=0.
- Terminal count coinciding with lap_clear in RUN: the snapshot captures the pre-increment time.
- Display source: live internal time in every state except LAP.

Optional Feature:
STOPWATCH_BCD_EN
- Defined: sec and min outputs are packed two-digit BCD (e.g. 59 s -> 8'h59, 12 min -> 8'h12). Digit counters are used internally; MAX_MIN must be <=99.
- Undefined: sec and min are plain unsigned binary (59 -> 8'd59).
- State machine, timing and overflow behaviour are identical in both builds.

Test Plan:
1. Reset with CLK_DIV=4: rst=1 for 3 cycles with random command pulses -> sec=0, min=0, running=0, lap_active=0, overflow=0, tick_out=0.
2. Count and wrap: start_stop pulse, then 240 cycles -> 60 tick_out pulses spaced exactly 4 cycles apart; final min=1, sec=0 (BCD: 8'h01/8'h00).
3. Pause/resume: pause 2 cycles after the 10th tick, hold 100 cycles -> sec stays 10. Resume -> next tick after exactly 2 cycles, sec=11.
4. Lap: lap_clear at sec=5 -> display stays 5 while running=1 and tick_out keeps pulsing. After 3 more ticks, lap_clear -> display 8 next cycle.
5. Overflow and clear: run 6000 ticks -> min=99, sec=59, overflow=1, running=0. Further cycles change nothing. lap_clear -> 0:00, overflow=0, IDLE.
6. Corners:
   - start_stop and lap_clear together in IDLE -> RUN, lap_active=0.
   - rst asserted mid-RUN at sec=7 -> all outputs 0 after the edge.
   - start_stop on a terminal-count cycle -> tick_out=1, sec+1, then PAUSE.
